parking_gate_arbiter: RTL and testbench

//  Shares the single lot gate between entrance and exit requesters, tracks lot occupancy, and sequences the

---
 rtl/parking_gate_if.sv | 25 ++
 rtl/parking_gate_arbiter.sv | 86 ++++++++
 tb/tb_parking_gate_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_if.sv
// parking_gate_if: sensor/keypad requests in, gate/LED/occupancy status out.
interface parking_gate_if #(parameter int CNT_W = 4);
  logic             entry_req;
  logic             exit_req;
  logic             pass_ok;
  logic             pass_fail;
  logic             car_passed;
  logic             pass_req;
  logic             gate_open;
  logic             grant_entry;
  logic             grant_exit;
  logic             GREEN_LED;
  logic             RED_LED;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] occupancy;
  modport master (
    output entry_req, exit_req, pass_ok, pass_fail, car_passed,
    input  pass_req, gate_open, grant_entry, grant_exit, GREEN_LED, RED_LED, full, empty, occupancy
  );
  modport slave (
    input  entry_req, exit_req, pass_ok, pass_fail, car_passed,
    output pass_req, gate_open, grant_entry, grant_exit, GREEN_LED, RED_LED, full, empty, occupancy
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin gate sharing, password sequencing and occupancy tracking.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int PASS_TIMEOUT = 100,
  parameter int GATE_TIMEOUT = 50,
  parameter int DENY_CYCLES  = 20
) (
  input logic           clk,
  input logic           reset_n,
  parking_gate_if.slave bus
);
  localparam int TMAX = (PASS_TIMEOUT > GATE_TIMEOUT)
                      ? ((PASS_TIMEOUT > DENY_CYCLES) ? PASS_TIMEOUT : DENY_CYCLES)
                      : ((GATE_TIMEOUT > DENY_CYCLES) ? GATE_TIMEOUT : DENY_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, CHECK, OPEN_IN, OPEN_OUT, DENY} state_t;
  state_t           state, state_n;
  logic [TW-1:0]    timer;
  logic             last_entry, last_entry_n;
  logic [CNT_W-1:0] occ_n;
  logic             elig_in, elig_out, at_cap, at_zero;
  assign elig_in  = bus.entry_req & ~bus.full;
  assign elig_out = bus.exit_req & ~bus.empty;
  assign at_cap   = bus.occupancy == CNT_W'(CAPACITY);
  assign at_zero  = bus.occupancy == '0;
  always_comb begin
    state_n      = state;
    last_entry_n = last_entry;
    occ_n        = bus.occupancy;
    case (state)
      IDLE: begin
        // On a tie, entry wins only if the previous grant went to exit
        if (elig_in && (!elig_out || !last_entry)) begin
          state_n      = CHECK;
          last_entry_n = 1'b1;
        end else if (elig_out) begin
          state_n      = OPEN_OUT;
          last_entry_n = 1'b0;
        end
      end
      CHECK:
        state_n = (bus.pass_fail || timer == TW'(PASS_TIMEOUT - 1)) ? DENY
                : bus.pass_ok ? OPEN_IN : CHECK;
      OPEN_IN: begin
        state_n = (bus.car_passed || timer == TW'(GATE_TIMEOUT - 1)) ? IDLE : OPEN_IN;
        occ_n   = (bus.car_passed && !at_cap) ? bus.occupancy + CNT_W'(1) : bus.occupancy;
      end
      OPEN_OUT: begin
        state_n = (bus.car_passed || timer == TW'(GATE_TIMEOUT - 1)) ? IDLE : OPEN_OUT;
        occ_n   = (bus.car_passed && !at_zero) ? bus.occupancy - CNT_W'(1) : bus.occupancy;
      end
      DENY:    state_n = (timer == TW'(DENY_CYCLES - 1)) ? IDLE : DENY;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      timer           <= '0;
      last_entry      <= 1'b0;
      bus.occupancy   <= '0;
      bus.full        <= 1'b0;
      bus.empty       <= 1'b1;
      bus.pass_req    <= 1'b0;
      bus.gate_open   <= 1'b0;
      bus.grant_entry <= 1'b0;
      bus.grant_exit  <= 1'b0;
      bus.GREEN_LED   <= 1'b0;
      bus.RED_LED     <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= (state_n != state || state == IDLE) ? '0 : timer + TW'(1);
      last_entry      <= last_entry_n;
      bus.occupancy   <= occ_n;
      bus.full        <= occ_n == CNT_W'(CAPACITY);
      bus.empty       <= occ_n == '0;
      bus.pass_req    <= state == IDLE && state_n == CHECK;
      bus.gate_open   <= state_n == OPEN_IN || state_n == OPEN_OUT;
      bus.grant_entry <= state_n == CHECK || state_n == OPEN_IN;
      bus.grant_exit  <= state_n == OPEN_OUT;
      bus.GREEN_LED   <= state_n == OPEN_IN || state_n == OPEN_OUT;
      bus.RED_LED     <= state_n == DENY;
    end
  end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed sequence with a grant-order scoreboard checked by a monitor.
module tb_parking_gate_arbiter;
  localparam int G_ENTRY = 1;
  localparam int G_EXIT  = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   model_occ = 0;
  int   exp_q[$];
  logic prev_gx = 1'b0;
  parking_gate_if #(.CNT_W(4)) bus ();
  parking_gate_arbiter #(
    .CAPACITY(8), .CNT_W(4), .PASS_TIMEOUT(100), .GATE_TIMEOUT(50), .DENY_CYCLES(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Each grant the DUT issues is matched against the next expected grant kind
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.pass_req) check("grant_order", G_ENTRY, (exp_q.size() != 0) ? exp_q.pop_front() : 0);
      if (bus.grant_exit && !prev_gx) check("grant_order", G_EXIT, (exp_q.size() != 0) ? exp_q.pop_front() : 0);
      prev_gx = bus.grant_exit;
    end else prev_gx = 1'b0;
  end
  task automatic wait_grant(output bit is_entry);
    int n = 0;
    while (!(bus.pass_req || bus.grant_exit) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait_timeout", int'(n >= 300), 0);
    is_entry = bus.pass_req;
  endtask
  task automatic serve(input int ok_dly, input int car_dly, input bit drop);
    bit is_entry;
    wait_grant(is_entry);
    if (drop) begin
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
    end
    if (is_entry) begin
      repeat (ok_dly) @(negedge clk);
      bus.pass_ok = 1'b1;
      @(negedge clk);
      bus.pass_ok = 1'b0;
      model_occ++;
    end else model_occ--;
    check("gate_open_during_open", int'(bus.gate_open), 1);
    check("green_during_open", int'(bus.GREEN_LED), 1);
    repeat (car_dly) @(negedge clk);
    bus.car_passed = 1'b1;
    @(negedge clk);
    bus.car_passed = 1'b0;
    check("occupancy_after_pass", int'(bus.occupancy), model_occ);
    check("gate_closed_after_pass", int'(bus.gate_open), 0);
  endtask
  task automatic wait_quiet();
    int n = 0;
    while ((bus.RED_LED || bus.gate_open || bus.grant_entry) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("quiet_wait_timeout", int'(n >= 300), 0);
  endtask
  initial begin
    bit is_entry;
    int cnt;
    int n;
    bus.entry_req = 1'b0; bus.exit_req = 1'b0; bus.pass_ok = 1'b0;
    bus.pass_fail = 1'b0; bus.car_passed = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_occupancy", int'(bus.occupancy), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_gate", int'(bus.gate_open), 0);
    check("rst_green", int'(bus.GREEN_LED), 0);
    check("rst_red", int'(bus.RED_LED), 0);
    check("rst_grants", int'({bus.pass_req, bus.grant_entry, bus.grant_exit}), 0);
    // Normal entry
    exp_q.push_back(G_ENTRY);
    bus.entry_req = 1'b1;
    serve(3, 3, 1'b1);
    check("entry_empty_low", int'(bus.empty), 0);
    // Rejected password: red for exactly DENY_CYCLES
    exp_q.push_back(G_ENTRY);
    bus.entry_req = 1'b1;
    wait_grant(is_entry);
    bus.entry_req = 1'b0;
    bus.pass_fail = 1'b1;
    @(negedge clk);
    bus.pass_fail = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.RED_LED) cnt++;
      @(negedge clk);
    end
    check("deny_red_cycles", cnt, 20);
    check("deny_occupancy", int'(bus.occupancy), model_occ);
    // No checker response: CHECK lasts PASS_TIMEOUT cycles
    exp_q.push_back(G_ENTRY);
    bus.entry_req = 1'b1;
    wait_grant(is_entry);
    bus.entry_req = 1'b0;
    cnt = 0;
    while (bus.grant_entry && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("check_timeout_cycles", cnt, 100);
    check("timeout_red", int'(bus.RED_LED), 1);
    wait_quiet();
    // Simultaneous ok and fail: fail wins
    exp_q.push_back(G_ENTRY);
    bus.entry_req = 1'b1;
    wait_grant(is_entry);
    bus.entry_req = 1'b0;
    bus.pass_ok = 1'b1;
    bus.pass_fail = 1'b1;
    @(negedge clk);
    bus.pass_ok = 1'b0;
    bus.pass_fail = 1'b0;
    check("both_pulses_red", int'(bus.RED_LED), 1);
    check("both_pulses_gate", int'(bus.gate_open), 0);
    wait_quiet();
    // Fill the lot
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(G_ENTRY);
      bus.entry_req = 1'b1;
      serve(1, 1, 1'b1);
    end
    check("fill_occupancy", int'(bus.occupancy), 8);
    check("fill_full", int'(bus.full), 1);
    bus.entry_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.pass_req || bus.grant_entry || bus.RED_LED) cnt++;
    end
    check("full_no_entry_activity", cnt, 0);
    exp_q.push_back(G_EXIT);
    bus.exit_req = 1'b1;
    serve(0, 2, 1'b1);
    check("exit_occupancy", int'(bus.occupancy), 7);
    check("exit_full_low", int'(bus.full), 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(G_EXIT);
      bus.exit_req = 1'b1;
      serve(0, 1, 1'b1);
    end
    check("drain_occupancy", int'(bus.occupancy), 3);
    // Held simultaneous requests alternate, entry first after an exit
    exp_q.push_back(G_ENTRY); exp_q.push_back(G_EXIT);
    exp_q.push_back(G_ENTRY); exp_q.push_back(G_EXIT);
    bus.entry_req = 1'b1;
    bus.exit_req = 1'b1;
    for (int i = 0; i < 4; i++) serve(1, 1, 1'b0);
    bus.entry_req = 1'b0;
    bus.exit_req = 1'b0;
    check("rr_occupancy", int'(bus.occupancy), 3);
    // Gate timeout in OPEN_IN
    exp_q.push_back(G_ENTRY);
    bus.entry_req = 1'b1;
    wait_grant(is_entry);
    bus.entry_req = 1'b0;
    bus.pass_ok = 1'b1;
    @(negedge clk);
    bus.pass_ok = 1'b0;
    cnt = 0;
    while (bus.gate_open && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("gate_timeout_cycles", cnt, 50);
    check("gate_timeout_occupancy", int'(bus.occupancy), 3);
    // Async reset in the middle of OPEN_IN
    exp_q.push_back(G_ENTRY);
    bus.entry_req = 1'b1;
    wait_grant(is_entry);
    bus.entry_req = 1'b0;
    bus.pass_ok = 1'b1;
    @(negedge clk);
    bus.pass_ok = 1'b0;
    check("pre_reset_gate", int'(bus.gate_open), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_gate", int'(bus.gate_open), 0);
    check("async_reset_occupancy", int'(bus.occupancy), 0);
    check("async_reset_empty", int'(bus.empty), 1);
    @(negedge clk);
    reset_n = 1'b1;
    model_occ = 0;
    n = 0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", int'({bus.gate_open, bus.grant_entry, bus.RED_LED}), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
